// File: rtl/seq_signal_mixer.sv
// Sequential voice mixer: snapshots a frame on start, accumulates one channel
// per clock, then applies the overflow policy and emits one registered sample.
module seq_signal_mixer #(
    parameter int NCH   = 12,
    parameter int SW    = 8,
    parameter int MODE  = 1,
    parameter int SHIFT = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [NCH*SW-1:0] samples_in,
    input  logic [NCH-1:0]    sample_enable,
    output logic [SW-1:0]     sample_out,
    output logic              sample_valid,
    output logic              clip,
    output logic              busy,
    output logic              overrun
);

    localparam int IW = $clog2(NCH);
    localparam int AW = SW + IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);
    localparam logic [AW-1:0] MAX_V    = AW'((1 << SW) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state;
    logic [AW-1:0]       acc;
    logic [IW-1:0]       idx;
    logic [NCH*SW-1:0]   snap_samples;
    logic [NCH-1:0]      snap_en;

    logic [AW-1:0]       chan_ext;
    logic [AW-1:0]       scaled;
    logic [SW-1:0]       res_out;
    logic                res_clip;

    // Handshake: start is a one-cycle request honoured only in IDLE (any start
    // seen in ACCUM or FINISH is dropped and latches overrun); sample_valid is a
    // one-cycle result strobe with no back-pressure, so the consumer must take
    // sample_out/clip in that cycle (they are held afterwards anyway).
    always_comb begin
        chan_ext = '0;
        if (snap_en[idx]) begin
            chan_ext[SW-1:0] = snap_samples[idx*SW +: SW];
        end

        scaled = (MODE == 2) ? (acc >> SHIFT) : acc;
        res_clip = (scaled > MAX_V);
        if (MODE == 0) begin
            res_out = acc[SW-1:0];
        end else if (res_clip) begin
            res_out = '1;
        end else begin
            res_out = scaled[SW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state        <= IDLE;
            acc          <= '0;
            idx          <= '0;
            snap_samples <= '0;
            snap_en      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            clip         <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_samples <= samples_in;
                        snap_en      <= sample_enable;
                        acc          <= '0;
                        idx          <= '0;
                        busy         <= 1'b1;
                        state        <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (start) begin
                        overrun <= 1'b1;
                    end
                    acc <= acc + chan_ext;
                    // Index is parked at 0 after the last channel so it never
                    // addresses past the snapshot.
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= FINISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                FINISH: begin
                    if (start) begin
                        overrun <= 1'b1;
                    end
                    sample_out   <= res_out;
                    clip         <= res_clip;
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signal_mixer.sv
// Bench for seq_signal_mixer: wrap, saturate and shift-saturate instances share
// the same stimulus and are compared against an arithmetic reference model.
module tb_seq_signal_mixer;

    localparam int NCH   = 12;
    localparam int SW    = 8;
    localparam int SHIFT = 2;
    localparam int TW    = NCH * SW;
    localparam int W     = 3 * (SW + 1);

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic [TW-1:0]     samples_in;
    logic [NCH-1:0]    sample_enable;
    logic [SW-1:0]     sample_out [3];
    logic [2:0]        valid_v;
    logic [2:0]        clip_v;
    logic [2:0]        busy_v;
    logic [2:0]        ovr_v;

    int                checks = 0;
    int                errors = 0;
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      last_exp;
    logic [W-1:0]      exp_word;
    bit                exp_ovr;
    int                valid_count;

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    seq_signal_mixer #(.NCH(NCH), .SW(SW), .MODE(0), .SHIFT(SHIFT)) u_wrap (
        .clk(clk), .n_rst(n_rst), .start(start),
        .samples_in(samples_in), .sample_enable(sample_enable),
        .sample_out(sample_out[0]), .sample_valid(valid_v[0]),
        .clip(clip_v[0]), .busy(busy_v[0]), .overrun(ovr_v[0])
    );

    seq_signal_mixer #(.NCH(NCH), .SW(SW), .MODE(1), .SHIFT(SHIFT)) u_sat (
        .clk(clk), .n_rst(n_rst), .start(start),
        .samples_in(samples_in), .sample_enable(sample_enable),
        .sample_out(sample_out[1]), .sample_valid(valid_v[1]),
        .clip(clip_v[1]), .busy(busy_v[1]), .overrun(ovr_v[1])
    );

    seq_signal_mixer #(.NCH(NCH), .SW(SW), .MODE(2), .SHIFT(SHIFT)) u_shift (
        .clk(clk), .n_rst(n_rst), .start(start),
        .samples_in(samples_in), .sample_enable(sample_enable),
        .sample_out(sample_out[2]), .sample_valid(valid_v[2]),
        .clip(clip_v[2]), .busy(busy_v[2]), .overrun(ovr_v[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [SW:0] ref_mix(input logic [TW-1:0] s,
                                            input logic [NCH-1:0] e,
                                            input int mode);
        int sum;
        int v;
        int maxv;
        sum  = 0;
        maxv = (1 << SW) - 1;
        for (int i = 0; i < NCH; i++) begin
            if (e[i]) sum += int'(s[i*SW +: SW]);
        end
        if (mode == 0) return {sum > maxv, SW'(sum % (maxv + 1))};
        v = (mode == 2) ? (sum >> SHIFT) : sum;
        return {v > maxv, SW'((v > maxv) ? maxv : v)};
    endfunction

    function automatic logic [W-1:0] ref_frame(input logic [TW-1:0] s,
                                               input logic [NCH-1:0] e);
        return {ref_mix(s, e, 2), ref_mix(s, e, 1), ref_mix(s, e, 0)};
    endfunction

    function automatic logic [TW-1:0] rand_samples();
        logic [TW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*SW +: SW] = SW'($urandom_range(0, 255));
        return r;
    endfunction

    function automatic logic [TW-1:0] fill(input logic [SW-1:0] v);
        logic [TW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*SW +: SW] = v;
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [W-1:0] e, input logic [2:0] v);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_mode%0d_clip_out", tag, k),
                  {23'd0, clip_v[k], sample_out[k]}, {23'd0, e[k*(SW+1) +: SW+1]});
        end
        check({tag, "_valid"}, {29'd0, valid_v}, {29'd0, v});
    endtask

    task automatic check_status(input string tag, input logic [2:0] busy_exp);
        check({tag, "_busy"}, {29'd0, busy_v}, {29'd0, busy_exp});
        check({tag, "_overrun"}, {29'd0, ovr_v}, {29'd0, {3{exp_ovr}}});
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [TW-1:0] s, input logic [NCH-1:0] e);
        int n;
        bit seen;
        logic [W-1:0] expv;
        samples_in    = s;
        sample_enable = e;
        start         = 1'b1;
        exp_q.push_back(ref_frame(s, e));
        step();
        start         = 1'b0;
        samples_in    = rand_samples();
        sample_enable = NCH'($urandom);
        check_outputs("hold", last_exp, 3'b000);
        check("busy_on", {29'd0, busy_v}, 32'd7);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 3 * NCH) begin
            step();
            n++;
            if (valid_v != 3'b000) seen = 1'b1;
        end
        check("latency", n, NCH + 1);
        expv = exp_q.pop_front();
        if (seen) begin
            check_outputs("result", expv, 3'b111);
            last_exp = expv;
        end
        check_status("done", 3'b000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_ovr       = 1'b0;
        last_exp      = '0;
        n_rst         = 1'b1;
        start         = 1'b1;
        samples_in    = rand_samples();
        sample_enable = NCH'($urandom);

        for (int i = 0; i < 3; i++) begin
            step();
            samples_in    = rand_samples();
            sample_enable = NCH'($urandom);
            check_outputs("reset", '0, 3'b000);
            check_status("reset", 3'b000);
        end
        n_rst = 1'b0;
        start = 1'b0;
        step();

        // Directed frames.
        begin
            logic [TW-1:0] s;
            s = fill(8'd255);
            s[0*SW +: SW] = 8'd100;
            s[1*SW +: SW] = 8'd50;
            run_frame(s, 12'h003);
        end
        run_frame(fill(8'd200), 12'h007);
        run_frame(fill(8'd255), 12'hFFF);
        run_frame(fill(8'd80),  12'hFFF);
        run_frame(rand_samples(), 12'h000);
        run_frame(fill(8'd21),  12'hFFF);

        // Random frames, back to back at the earliest accepted start.
        for (int f = 0; f < 12; f++) begin
            run_frame(rand_samples(), NCH'($urandom));
        end

        // Snapshot isolation and overrun: starts at edges 5 and 13 are ignored.
        samples_in          = fill(8'hFF);
        samples_in[SW-1:0]  = 8'd10;
        sample_enable       = NCH'(1);
        start               = 1'b1;
        exp_q.push_back(ref_frame(samples_in, sample_enable));
        step();
        start      = 1'b0;
        samples_in = fill(8'hFF);
        repeat (4) step();
        check("overrun_before", {29'd0, ovr_v}, 32'd0);
        start = 1'b1;
        step();
        start   = 1'b0;
        exp_ovr = 1'b1;
        check_status("overrun_set", 3'b111);
        repeat (7) step();
        check("no_early_valid", {29'd0, valid_v}, 32'd0);
        start = 1'b1;
        step();
        start    = 1'b0;
        exp_word = exp_q.pop_front();
        check_outputs("snapshot", exp_word, 3'b111);
        last_exp = exp_word;
        check_status("overrun_hold", 3'b000);
        run_frame(fill(8'hFF), NCH'(1));

        // Reset in the middle of ACCUM aborts the frame silently.
        samples_in    = rand_samples();
        sample_enable = '1;
        start         = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        n_rst = 1'b1;
        step();
        n_rst    = 1'b0;
        exp_ovr  = 1'b0;
        last_exp = '0;
        check_outputs("abort", '0, 3'b000);
        check_status("abort", 3'b000);
        valid_count = 0;
        repeat (2 * NCH) begin
            step();
            if (valid_v != 3'b000) valid_count++;
        end
        check("abort_no_valid", valid_count, 0);
        run_frame(rand_samples(), NCH'($urandom));
        run_frame(rand_samples(), '1);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
